// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader for the core's instruction memory.
// Assembles 9-bit words from a byte stream (header count, then lo/hi byte
// pairs), writes them to consecutive addresses while holding the core in
// reset, then releases the core and counts run cycles until core_done.
// Ports:
//   clk, reset (async active-low)   clock and reset
//   start                           begin a load (IDLE/FIN/ERR only)
//   in_valid/in_data/in_ready       byte stream handshake
//   wr_en/wr_addr/wr_data           instruction-memory write port
//   core_reset/core_done            core control (1 = hold in reset) / done
//   busy/loaded/err                 status flags
//   cycle_cnt                       core run length in cycles (saturating)
`timescale 1ns/1ps
module prog_loader #(
  parameter int D  = 12,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          wr_en,
  output logic [D-1:0]  wr_addr,
  output logic [8:0]    wr_data,
  output logic          core_reset,
  input  logic          core_done,
  output logic          busy,
  output logic          loaded,
  output logic          err,
  output logic [CW-1:0] cycle_cnt
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_HDR_LO = 4'd1,
    S_HDR_HI = 4'd2,
    S_WLO    = 4'd3,
    S_WHI    = 4'd4,
    S_LAST   = 4'd5,
    S_RUN    = 4'd6,
    S_FIN    = 4'd7,
    S_ERR    = 4'd8
  } state_t;

  state_t        state_q, state_d;
  logic [D-1:0]  count_q, count_d;
  logic [D-1:0]  addr_q, addr_d;
  logic [7:0]    lo_q, lo_d;
  logic [8:0]    data_q, data_d;
  logic          wr_en_q, wr_en_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          accept_s;
  logic [D-1:0]  hdr_count_s;

  localparam logic [D-1:0]  ADDR_ONE = {{(D-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  // Status outputs are pure decodes of the state register.
  assign in_ready   = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                      (state_q == S_WLO)    || (state_q == S_WHI);
  assign busy       = in_ready || (state_q == S_LAST);
  assign loaded     = (state_q == S_FIN);
  assign err        = (state_q == S_ERR);
  assign core_reset = !((state_q == S_RUN) || (state_q == S_FIN));

  assign wr_en      = wr_en_q;
  assign wr_addr    = addr_q;
  assign wr_data    = data_q;
  assign cycle_cnt  = cnt_q;

  assign accept_s    = in_valid && in_ready;
  // Full count as it will be once the high header byte is taken; upper
  // bits of that byte beyond the address width are dropped.
  assign hdr_count_s = {in_data[D-9:0], count_q[7:0]};

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    data_d  = data_q;
    wr_en_d = 1'b0;
    cnt_d   = cnt_q;

    // The address advances on the edge that ends the write strobe, so it
    // is stable for the whole strobe cycle.
    if (wr_en_q) begin
      addr_d = addr_q + ADDR_ONE;
    end else begin
      addr_d = addr_q;
    end

    case (state_q)
      S_IDLE, S_FIN, S_ERR: begin
        if (start) begin
          state_d = S_HDR_LO;
          addr_d  = '0;
        end else begin
          state_d = state_q;
        end
      end
      S_HDR_LO: begin
        if (accept_s) begin
          count_d[7:0] = in_data;
          state_d      = S_HDR_HI;
        end else begin
          state_d = S_HDR_LO;
        end
      end
      S_HDR_HI: begin
        if (accept_s) begin
          count_d = hdr_count_s;
          if (hdr_count_s != '0) begin
            state_d = S_WLO;
          end else begin
            state_d = S_RUN;
            cnt_d   = '0;
          end
        end else begin
          state_d = S_HDR_HI;
        end
      end
      S_WLO: begin
        if (accept_s) begin
          lo_d    = in_data;
          state_d = S_WHI;
        end else begin
          state_d = S_WLO;
        end
      end
      S_WHI: begin
        if (accept_s) begin
          if (in_data[7:1] == 7'd0) begin
            data_d  = {in_data[0], lo_q};
            wr_en_d = 1'b1;
            if (addr_q == (count_q - ADDR_ONE)) begin
              state_d = S_LAST;
            end else begin
              state_d = S_WLO;
            end
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_WHI;
        end
      end
      S_LAST: begin
        state_d = S_RUN;
        cnt_d   = '0;
      end
      S_RUN: begin
        // core_done takes priority over the increment.
        if (core_done) begin
          state_d = S_FIN;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      addr_q  <= '0;
      lo_q    <= 8'd0;
      data_q  <= 9'd0;
      wr_en_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      data_q  <= data_d;
      wr_en_q <= wr_en_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
